// File: rtl/i2c_target.sv
// Single-address I2C target: synchronised and glitch-filtered SCL/SDA, START/STOP detection, ACKed writes and reads.
// Bus events act about 2+FILTER_LEN cycles after the pins. There is no clock stretching, so user logic must present tx_data in the cycle tx_req=1.
module i2c_target #(
  parameter logic [6:0]  TARGET_ADDR = 7'b0111011,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       rw,
  output logic       busy
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_IGNORE
  } state_t;

  logic [1:0]    scl_sync, sda_sync;
  logic [CW-1:0] scl_cnt, sda_cnt;
  logic          scl_f, sda_f, scl_p, sda_p;
  logic          scl_rise, scl_fall, start_c, stop_c;

  state_t     state, state_nx;
  logic [7:0] shift, shift_nx, shift_in, rx_data_nx;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic       sda_low, sda_low_nx, rx_valid_nx, rw_nx, busy_nx, load_tx;

  // The open-drain pad releases as soon as sda_low clears, including on async reset.
  assign sda = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_cnt  <= '0;
      sda_cnt  <= '0;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_p    <= 1'b1;
      sda_p    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_p    <= scl_f;
      sda_p    <= sda_f;
      // A filtered level only follows after FILTER_LEN consecutive differing samples.
      if (scl_sync[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == CW'(FILTER_LEN - 1)) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 1'b1;
      end
      if (sda_sync[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == CW'(FILTER_LEN - 1)) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 1'b1;
      end
    end
  end

  assign scl_rise = scl_f & ~scl_p;
  assign scl_fall = ~scl_f & scl_p;
  assign start_c  = scl_f & scl_p & sda_p & ~sda_f;
  assign stop_c   = scl_f & scl_p & ~sda_p & sda_f;
  assign shift_in = {shift[6:0], sda_f};

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      sda_low  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rw       <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      shift    <= shift_nx;
      bit_cnt  <= bit_cnt_nx;
      sda_low  <= sda_low_nx;
      rx_data  <= rx_data_nx;
      rx_valid <= rx_valid_nx;
      rw       <= rw_nx;
      busy     <= busy_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    shift_nx    = shift;
    bit_cnt_nx  = bit_cnt;
    sda_low_nx  = sda_low;
    rx_data_nx  = rx_data;
    rx_valid_nx = 1'b0;
    rw_nx       = rw;
    busy_nx     = busy;
    tx_req      = 1'b0;
    load_tx     = 1'b0;

    if (start_c) begin
      state_nx   = S_ADDR;
      bit_cnt_nx = '0;
      sda_low_nx = 1'b0;
      busy_nx    = 1'b0;
    end else if (stop_c) begin
      state_nx   = S_IDLE;
      sda_low_nx = 1'b0;
      busy_nx    = 1'b0;
    end else begin
      case (state)
        S_ADDR, S_WRITE: begin
          if (scl_rise) begin
            shift_nx   = shift_in;
            bit_cnt_nx = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == S_WRITE) begin
                rx_data_nx  = shift_in;
                rx_valid_nx = 1'b1;
                state_nx    = S_WRITE_ACK;
              end else if (shift_in[7:1] == TARGET_ADDR) begin
                rw_nx    = shift_in[0];
                busy_nx  = 1'b1;
                state_nx = S_ADDR_ACK;
              end else begin
                state_nx = S_IGNORE;
              end
            end
          end
        end
        // sda_low doubles as the ACK phase marker: the first fall asserts it, the second ends the ACK bit.
        S_ADDR_ACK, S_WRITE_ACK: begin
          if (scl_fall) begin
            if (!sda_low) begin
              sda_low_nx = 1'b1;
            end else if (state == S_ADDR_ACK && rw) begin
              load_tx = 1'b1;
            end else begin
              sda_low_nx = 1'b0;
              state_nx   = S_WRITE;
            end
          end
        end
        S_READ: begin
          if (scl_rise) begin
            bit_cnt_nx = bit_cnt + 3'd1;
          end
          if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              sda_low_nx = 1'b0;
              state_nx   = S_READ_ACK;
            end else begin
              shift_nx   = {shift[6:0], 1'b0};
              sda_low_nx = ~shift[6];
            end
          end
        end
        // A fall can only arrive here after an ACK, since a NACK leaves on the rise.
        S_READ_ACK: begin
          if (scl_rise && sda_f) begin
            busy_nx  = 1'b0;
            state_nx = S_IGNORE;
          end else if (scl_fall) begin
            load_tx = 1'b1;
          end
        end
        default: ;
      endcase

      if (load_tx) begin
        tx_req     = 1'b1;
        shift_nx   = tx_data;
        sda_low_nx = ~tx_data[7];
        bit_cnt_nx = '0;
        state_nx   = S_READ;
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged I2C master, directed scenarios plus randomized transfers checked against a transaction-level model.
module tb_i2c_target;

  localparam int Q = 8;

  logic       CLOCK_50 = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        sda;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, rw, busy;

  int total = 0;
  int bad = 0;
  int rx_cnt = 0;
  int txr_cnt = 0;
  int dut_low_cnt = 0;
  int rx_chk = 0;
  int exp_txr = 0;
  logic [7:0] rx_log [0:255];
  logic [7:0] exp_rx [$];

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_target dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .scl      (m_scl),
    .sda      (sda),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .rw       (rw),
    .busy     (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (rx_valid) begin
      rx_log[rx_cnt[7:0]] = rx_data;
      rx_cnt++;
    end
    if (tx_req) txr_cnt++;
    if (!sda && !m_sda_low) dut_low_cnt++;
  end

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #2;
  endtask

  task automatic clk_bit(input logic b, input logic gl, output logic got);
    m_sda_low = ~b;
    if (gl) begin
      wait_cyc(3);
      m_scl = 1'b1;
      wait_cyc(1);
      m_scl = 1'b0;
      wait_cyc(Q - 4);
    end else begin
      wait_cyc(Q);
    end
    m_scl = 1'b1;
    wait_cyc(Q);
    got = sda;
    m_scl = 1'b0;
    wait_cyc(Q);
  endtask

  task automatic m_start();
    if (!m_scl) begin
      m_sda_low = 1'b0;
      wait_cyc(Q);
      m_scl = 1'b1;
      wait_cyc(Q);
    end
    m_sda_low = 1'b1;
    wait_cyc(Q);
    m_scl = 1'b0;
    wait_cyc(Q);
  endtask

  task automatic m_stop();
    m_sda_low = 1'b1;
    wait_cyc(Q);
    m_scl = 1'b1;
    wait_cyc(Q);
    m_sda_low = 1'b0;
    wait_cyc(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input logic gl, output logic ack);
    logic g;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], gl && (i == 4), g);
    clk_bit(1'b1, 1'b0, ack);
  endtask

  task automatic read_byte(input logic nack, input logic [7:0] next, output logic [7:0] d);
    logic g;
    for (int i = 7; i >= 0; i--) clk_bit(1'b1, 1'b0, d[i]);
    tx_data = next;
    clk_bit(nack, 1'b0, g);
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_rxcnt"}, rx_cnt, rx_chk + exp_rx.size());
    while (exp_rx.size() > 0) begin
      chk({tag, "_rxdat"}, rx_log[rx_chk[7:0]], exp_rx.pop_front());
      rx_chk++;
    end
  endtask

  initial begin
    logic       a0, a1, g;
    logic [7:0] d;
    int         l0;

    wait_cyc(3);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_tx_req", tx_req, 1'b0);
    chk("rst_rw", rw, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sda", sda, 1'b1);
    rst_n = 1'b1;
    wait_cyc(4);

    // Addressed write of one byte.
    m_start();
    write_byte(8'h76, 1'b0, a0);
    chk("t1_busy_on", busy, 1'b1);
    chk("t1_rw", rw, 1'b0);
    write_byte(8'h7D, 1'b0, a1);
    m_stop();
    chk("t1_addr_ack", a0, 1'b0);
    chk("t1_data_ack", a1, 1'b0);
    exp_rx.push_back(8'h7D);
    check_rx("t1");
    chk("t1_busy_off", busy, 1'b0);
    chk("t1_sda_idle", sda, 1'b1);

    // Foreign address: the target stays silent.
    l0 = dut_low_cnt;
    m_start();
    write_byte(8'h78, 1'b0, a0);
    chk("t2_busy", busy, 1'b0);
    write_byte(8'h55, 1'b0, a1);
    m_stop();
    chk("t2_addr_nack", a0, 1'b1);
    chk("t2_data_nack", a1, 1'b1);
    chk("t2_never_low", dut_low_cnt, l0);
    check_rx("t2");

    // Two-byte read, ACK then NACK.
    tx_data = 8'hA5;
    m_start();
    write_byte(8'h77, 1'b0, a0);
    chk("t3_addr_ack", a0, 1'b0);
    chk("t3_rw", rw, 1'b1);
    read_byte(1'b0, 8'h3C, d);
    chk("t3_byte0", d, 8'hA5);
    read_byte(1'b1, 8'h00, d);
    chk("t3_byte1", d, 8'h3C);
    chk("t3_busy_nack", busy, 1'b0);
    m_stop();
    exp_txr += 2;
    chk("t3_tx_req", txr_cnt, exp_txr);

    // Write, repeated START, then read one byte.
    m_start();
    write_byte(8'h76, 1'b0, a0);
    chk("t4_rw_w", rw, 1'b0);
    write_byte(8'h12, 1'b0, a1);
    chk("t4_data_ack", a1, 1'b0);
    tx_data = 8'h99;
    m_start();
    write_byte(8'h77, 1'b0, a0);
    chk("t4_raddr_ack", a0, 1'b0);
    chk("t4_rw_r", rw, 1'b1);
    read_byte(1'b1, 8'h00, d);
    chk("t4_read", d, 8'h99);
    m_stop();
    exp_rx.push_back(8'h12);
    check_rx("t4");
    exp_txr += 1;
    chk("t4_tx_req", txr_cnt, exp_txr);

    // STOP after four data bits discards the partial byte.
    m_start();
    write_byte(8'h76, 1'b0, a0);
    for (int i = 0; i < 4; i++) clk_bit(i[0], 1'b0, g);
    m_stop();
    chk("t5_busy", busy, 1'b0);
    chk("t5_sda", sda, 1'b1);
    check_rx("t5_abort");
    m_start();
    write_byte(8'h76, 1'b0, a0);
    write_byte(8'h01, 1'b0, a1);
    m_stop();
    chk("t5_ack", a1, 1'b0);
    exp_rx.push_back(8'h01);
    check_rx("t5_next");

    // Single-cycle SCL glitch inside a data byte.
    m_start();
    write_byte(8'h76, 1'b0, a0);
    write_byte(8'h7D, 1'b1, a1);
    m_stop();
    chk("t6_ack", a1, 1'b0);
    exp_rx.push_back(8'h7D);
    check_rx("t6");

    // Randomized transfers against the transaction model.
    for (int t = 0; t < 6; t++) begin
      logic       match, dir;
      logic [6:0] addr;
      logic [7:0] rb [0:3];
      int         nb;
      match = ($urandom_range(0, 3) != 0);
      addr  = 7'($urandom_range(0, 127));
      if (match) addr = 7'h3B;
      else if (addr == 7'h3B) addr = 7'h3A;
      dir = 1'($urandom_range(0, 1));
      nb  = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) rb[i] = 8'($urandom);
      tx_data = rb[0];
      m_start();
      write_byte({addr, dir}, 1'b0, a0);
      chk("rnd_addr_ack", a0, !match);
      for (int i = 0; i < nb; i++) begin
        if (!dir) begin
          write_byte(rb[i], 1'b0, a1);
          chk("rnd_wr_ack", a1, !match);
          if (match) exp_rx.push_back(rb[i]);
        end else begin
          read_byte(i == nb - 1, rb[i + 1], d);
          chk("rnd_rd_data", d, match ? rb[i] : 8'hFF);
        end
      end
      m_stop();
      if (match && dir) exp_txr += nb;
      chk("rnd_busy", busy, 1'b0);
      chk("rnd_tx_req", txr_cnt, exp_txr);
      check_rx("rnd");
    end

    // Reset while the target pulls the address ACK low.
    tx_data = 8'h00;
    m_start();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] ab;
      ab = 8'h77;
      clk_bit(ab[i], 1'b0, g);
    end
    m_sda_low = 1'b0;
    wait_cyc(Q);
    m_scl = 1'b1;
    wait_cyc(Q / 2);
    chk("t8_ack_driven", sda, 1'b0);
    chk("t8_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t8_sda_released", sda, 1'b1);
    chk("t8_busy", busy, 1'b0);
    chk("t8_rw", rw, 1'b0);
    chk("t8_rx_data", rx_data, 8'h00);
    chk("t8_rx_valid", rx_valid, 1'b0);
    chk("t8_tx_req", tx_req, 1'b0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
